// File: rtl/sprite_draw_arbiter.sv
// sprite_draw_arbiter: round-robin sharing of the vga_adapter write port between rectangle sprite sources
// Ports: clock/resetn (async active-low); req, x_in, y_in, w_in, h_in, colour_in are packed per-source requests;
// grant/done are one-hot pulses; busy spans grant through done; vga_x/vga_y/vga_colour/vga_plot drive vga_adapter.
module sprite_draw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SIZE_W = 4,
  parameter int COLOUR_W = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       x_in,
  input  logic [NUM_REQ*Y_W-1:0]       y_in,
  input  logic [NUM_REQ*SIZE_W-1:0]    w_in,
  input  logic [NUM_REQ*SIZE_W-1:0]    h_in,
  input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
  state_t state;
  logic [IW-1:0] last, sel, pick;
  logic [IW:0] k;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [SIZE_W-1:0] w, h, dx, dy;
  logic [COLOUR_W-1:0] col;
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  logic on_screen, last_col;
  // Scan downward from last+NUM_REQ to last+1 so the final hit is the first set bit above last.
  always_comb begin
    pick = '0;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (IW+1)'(last) + (IW+1)'(i);
      k = k >= (IW+1)'(NUM_REQ) ? k - (IW+1)'(NUM_REQ) : k;
      if (req[k[IW-1:0]]) pick = k[IW-1:0];
    end
  end
  // One extra bit keeps off-screen sums from wrapping back onto column/row 0.
  assign sx = {1'b0, x0} + (X_W+1)'(dx);
  assign sy = {1'b0, y0} + (Y_W+1)'(dy);
  assign on_screen = sx <= (X_W+1)'(X_MAX) && sy <= (Y_W+1)'(Y_MAX);
  assign last_col = dx == w;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last <= IW'(NUM_REQ-1);
      sel <= '0;
      grant <= '0;
      done <= '0;
      busy <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
      x0 <= '0;
      y0 <= '0;
      w <= '0;
      h <= '0;
      col <= '0;
      dx <= '0;
      dy <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          vga_plot <= 1'b0;
          busy <= |req;
          grant <= |req ? NUM_REQ'(1) << pick : '0;
          sel <= pick;
          x0 <= x_in[pick*X_W +: X_W];
          y0 <= y_in[pick*Y_W +: Y_W];
          w <= w_in[pick*SIZE_W +: SIZE_W];
          h <= h_in[pick*SIZE_W +: SIZE_W];
          col <= colour_in[pick*COLOUR_W +: COLOUR_W];
          dx <= '0;
          dy <= '0;
          state <= |req ? DRAW : IDLE;
        end
        DRAW: begin
          grant <= '0;
          vga_plot <= on_screen;
          // Clipped pixels leave the last plotted coordinates on the bus.
          if (on_screen) begin
            vga_x <= sx[X_W-1:0];
            vga_y <= sy[Y_W-1:0];
            vga_colour <= col;
          end
          dx <= last_col ? '0 : dx + 1'b1;
          dy <= last_col ? dy + 1'b1 : dy;
          state <= last_col && dy == h ? FINISH : DRAW;
        end
        FINISH: begin
          vga_plot <= 1'b0;
          done <= NUM_REQ'(1) << sel;
          last <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// tb_sprite_draw_arbiter: directed bench with a per-cycle output model for sprite_draw_arbiter
module tb_sprite_draw_arbiter;
  localparam int N = 4, XW = 8, YW = 7, SW = 4, CW = 3;
  logic clock = 0, resetn = 1;
  logic [N-1:0] req = '0;
  logic [N*XW-1:0] x_in = '0;
  logic [N*YW-1:0] y_in = '0;
  logic [N*SW-1:0] w_in = '0, h_in = '0;
  logic [N*CW-1:0] colour_in = '0;
  logic [N-1:0] grant, done;
  logic busy, vga_plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  sprite_draw_arbiter dut (
    .clock(clock), .resetn(resetn), .req(req), .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in),
    .colour_in(colour_in), .grant(grant), .done(done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic p;
  } rec_t;
  rec_t q[$];
  rec_t exp_r, act, r;
  int last, s, fx, fy, fw, fh, px, py;
  logic [CW-1:0] fc, hc;
  logic [XW-1:0] hx;
  logic [YW-1:0] hy;
  logic [1:0] ix;
  int checks = 0, errors = 0, cyc = 0, busy_cnt = 0, pt_last = 0;
  bit chk_en = 0;
  logic [14:0] pix[$];
  int gq[$], gt[$], dq[$], dt[$];
  // Model: on arbitration, expand the whole rectangle into its expected output cycles.
  initial forever begin
    @(posedge clock or negedge resetn);
    if (!resetn) begin
      q.delete();
      last = N - 1;
      exp_r = '0;
      hx = '0;
      hy = '0;
      hc = '0;
    end else if (q.size() > 0) exp_r = q.pop_front();
    else if (req != '0) begin
      s = -1;
      for (int k = 1; k <= N; k++) begin
        ix = 2'((last + k) % N);
        if (s < 0 && req[ix]) s = int'(ix);
      end
      fx = int'(x_in[s*XW +: XW]);
      fy = int'(y_in[s*YW +: YW]);
      fw = int'(w_in[s*SW +: SW]);
      fh = int'(h_in[s*SW +: SW]);
      fc = colour_in[s*CW +: CW];
      exp_r = '0;
      exp_r.g = N'(1) << s;
      exp_r.b = 1'b1;
      exp_r.x = hx;
      exp_r.y = hy;
      exp_r.c = hc;
      for (int j = 0; j <= fh; j++)
        for (int i = 0; i <= fw; i++) begin
          r = '0;
          r.b = 1'b1;
          px = fx + i;
          py = fy + j;
          if (px <= 159 && py <= 119) begin
            hx = XW'(px);
            hy = YW'(py);
            hc = fc;
            r.p = 1'b1;
          end
          r.x = hx;
          r.y = hy;
          r.c = hc;
          q.push_back(r);
        end
      r = '0;
      r.b = 1'b1;
      r.d = N'(1) << s;
      r.x = hx;
      r.y = hy;
      r.c = hc;
      q.push_back(r);
      last = s;
    end else begin
      exp_r = '0;
      exp_r.x = hx;
      exp_r.y = hy;
      exp_r.c = hc;
    end
  end
  initial forever begin
    @(negedge clock);
    cyc++;
    if (chk_en) begin
      act = {grant, done, busy, vga_x, vga_y, vga_colour, vga_plot};
      checks++;
      if (act !== exp_r) begin
        errors++;
        $display("FAIL cycle %0d outputs (g,d,busy,x,y,c,plot): got %b %b %b %0d %0d %0d %b expected %b %b %b %0d %0d %0d %b",
                 cyc, act.g, act.d, act.b, act.x, act.y, act.c, act.p,
                 exp_r.g, exp_r.d, exp_r.b, exp_r.x, exp_r.y, exp_r.c, exp_r.p);
      end
      busy_cnt += int'(busy);
      if (vga_plot) begin
        pix.push_back({vga_x, vga_y});
        pt_last = cyc;
      end
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin gq.push_back(i); gt.push_back(cyc); end
        if (done[i]) begin dq.push_back(i); dt.push_back(cyc); end
      end
    end
  end
  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic tick;
    @(negedge clock);
    #1;
  endtask
  task automatic src(input int i, input int x, input int y, input int w, input int h, input int c);
    x_in[i*XW +: XW] = XW'(x);
    y_in[i*YW +: YW] = YW'(y);
    w_in[i*SW +: SW] = SW'(w);
    h_in[i*SW +: SW] = SW'(h);
    colour_in[i*CW +: CW] = CW'(c);
  endtask
  task automatic clr;
    pix.delete(); gq.delete(); gt.delete(); dq.delete(); dt.delete();
    busy_cnt = 0;
  endtask
  task automatic wait_g(input int n, input int budget);
    for (int k = 0; k < budget && gq.size() < n; k++) tick();
    chk("grant_wait", gq.size() >= n ? 1 : 0, 1);
  endtask
  task automatic wait_d(input int n, input int budget);
    for (int k = 0; k < budget && dq.size() < n; k++) tick();
    chk("done_wait", dq.size() >= n ? 1 : 0, 1);
  endtask
  task automatic do_reset;
    resetn = 0;
    #1;
    chk("reset_outputs", int'({grant, done, busy, vga_x, vga_y, vga_colour, vga_plot}), 0);
    tick();
    tick();
    resetn = 1;
  endtask
  initial begin
    #1;
    chk_en = 1;
    do_reset();
    // basic 2x2
    clr();
    src(0, 10, 20, 1, 1, 3);
    req = 4'b0001;
    wait_g(1, 10);
    req = '0;
    wait_d(1, 20);
    tick();
    chk("t1_busy_cycles", busy_cnt, 6);
    chk("t1_pixels", pix.size(), 4);
    chk("t1_pix0", int'(pix[0]), int'({8'd10, 7'd20}));
    chk("t1_pix1", int'(pix[1]), int'({8'd11, 7'd20}));
    chk("t1_pix2", int'(pix[2]), int'({8'd10, 7'd21}));
    chk("t1_pix3", int'(pix[3]), int'({8'd11, 7'd21}));
    chk("t1_done_src", dq[0], 0);
    chk("t1_grant_to_done", dt[0] - gt[0], 5);
    // round robin with all sources 1x1
    do_reset();
    clr();
    for (int i = 0; i < N; i++) src(i, 20 * i, 10, 0, 0, i + 1);
    req = 4'b1111;
    wait_g(5, 30);
    req = '0;
    wait_d(5, 20);
    chk("t2_g0", gq[0], 0);
    chk("t2_g1", gq[1], 1);
    chk("t2_g2", gq[2], 2);
    chk("t2_g3", gq[3], 3);
    chk("t2_g4", gq[4], 0);
    for (int k = 0; k < 4; k++) chk("t2_gap", gt[k+1] - gt[k], 3);
    // clipping at bottom-right corner
    tick();
    clr();
    src(1, 158, 118, 3, 3, 6);
    req = 4'b0010;
    wait_g(1, 10);
    req = '0;
    wait_d(1, 30);
    chk("t3_plotted", pix.size(), 4);
    chk("t3_first", int'(pix[0]), int'({8'd158, 7'd118}));
    chk("t3_last", int'(pix[3]), int'({8'd159, 7'd119}));
    chk("t3_grant_to_done", dt[0] - gt[0], 17);
    chk("t3_done_src", dq[0], 1);
    // fields change after grant
    tick();
    clr();
    src(2, 50, 5, 2, 0, 5);
    req = 4'b0100;
    wait_g(1, 10);
    src(2, 90, 5, 2, 0, 5);
    req = '0;
    wait_d(1, 20);
    chk("t4_pixels", pix.size(), 3);
    chk("t4_pix0", int'(pix[0]), int'({8'd50, 7'd5}));
    chk("t4_pix2", int'(pix[2]), int'({8'd52, 7'd5}));
    chk("t4_done_src", dq[0], 2);
    // reset during pixel 3 of a 4x4
    tick();
    clr();
    src(3, 30, 40, 3, 3, 4);
    req = 4'b1000;
    wait_g(1, 10);
    req = '0;
    for (int k = 0; k < 10 && pix.size() < 3; k++) tick();
    chk("t5_reached_pix3", pix.size(), 3);
    do_reset();
    chk("t5_no_done", dq.size(), 0);
    resetn = 0;
    clr();
    src(2, 60, 60, 0, 0, 2);
    req = 4'b0100;
    resetn = 1;
    tick();
    chk("t5_first_idle_grant", gq.size(), 1);
    chk("t5_grant_src", gq[0], 2);
    req = '0;
    wait_d(1, 10);
    chk("t5_done_src", dq[0], 2);
    // maximum 16x16
    tick();
    clr();
    src(0, 0, 0, 15, 15, 7);
    req = 4'b0001;
    wait_g(1, 10);
    req = '0;
    wait_d(1, 300);
    chk("t6_plotted", pix.size(), 256);
    chk("t6_last_pix", int'(pix[255]), int'({8'd15, 7'd15}));
    chk("t6_done_after_last", dt[0] - pt_last, 1);
    chk("t6_grant_to_done", dt[0] - gt[0], 257);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
